fetch_stage: RTL and testbench

Instruction fetch stage of the KASIRGA-GUN pipeline. It owns the program counter, fetches aligned 32-bit words from instruction memory over a single-outstanding request/response handshake, and splits them into 16-bit (RVC) or 32-bit instructions with a halfword parcel buffer. It drives the registered instruction, PC and branch-taken signals consumed by the decode stage, and obeys stall, flush and redirect commands from the pipeline controller and execute stage.

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 193 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
// Instruction-memory handshake between the fetch stage and instruction memory.
// A request is issued with imem_req_o/imem_addr_o and is accepted when
// imem_ready_i is high. The response comes back later on imem_valid_i/imem_data_i.
// Only one request is ever outstanding.
//   imem_req_o    fetch -> mem  request valid
//   imem_addr_o   fetch -> mem  word address, bits [1:0] always zero
//   imem_ready_i  mem -> fetch  request accepted this cycle
//   imem_valid_i  mem -> fetch  response word valid
//   imem_data_i   mem -> fetch  response word, little-endian halfwords
// Modports: master (fetch stage), slave (memory).

interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_valid_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ready_i, imem_valid_i, imem_data_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ready_i, imem_valid_i, imem_data_i
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch stage of the KASIRGA-GUN pipeline. It owns the program
// counter and fetches aligned 32-bit words over a single-outstanding handshake.
// It splits the words into 16-bit (RVC) or 32-bit instructions through a
// 4-halfword parcel buffer, and registers the instruction, PC and
// branch-taken outputs that feed decode.
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-low reset
//   stall_fetch_stage_i            hold the output registers
//   flush_fetch_stage_i            replace the next output with NOP
//   en_excep_program_counter_i /   exception/mret redirect (highest priority)
//   excep_program_counter_i
//   en_branch_redirect_i /         execute-stage mispredict redirect
//   branch_target_i
//   imem                           fetch_stage_if.master memory handshake
//   instruction_o                  instruction; RVC is zero-extended in [15:0]
//   program_counter_o              PC of instruction_o
//   branch_taken_o                 static prediction taken for this instruction
// Optional feature macro: FETCH_STATIC_PREDICT_EN enables static prediction of
// JAL and backward conditional branches. Without it, fetch is purely sequential.

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_fetch_stage_i,
  input  logic          flush_fetch_stage_i,
  input  logic          en_excep_program_counter_i,
  input  logic [31:0]   excep_program_counter_i,
  input  logic          en_branch_redirect_i,
  input  logic [31:0]   branch_target_i,
  fetch_stage_if.master imem,
  output logic [31:0]   instruction_o,
  output logic [31:0]   program_counter_o,
  output logic          branch_taken_o
);

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DISCARD} state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] RESET_ISSUE = {RESET_PC[31:1], 1'b0};

  state_t      state_q, state_d;
  logic [63:0] buf_q, buf_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        drop_low_q, drop_low_d;
  logic [31:0] issue_pc_q, issue_pc_d;

  logic        ext_redirect;
  logic [31:0] ext_target;
  logic        head_is32, have_instr, issue;
  logic [31:0] instr_word;
  logic [1:0]  pop;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        req_accept, write_en;
  logic [2:0]  count_pop, wr_cnt;
  logic [63:0] buf_pop, wr_data;

  assign ext_redirect = en_excep_program_counter_i | en_branch_redirect_i;
  assign ext_target   = en_excep_program_counter_i ? excep_program_counter_i : branch_target_i;

  // Halfword 0 of buf_q is the FIFO head. Entries at or above count_q are kept at zero.
  assign head_is32  = (buf_q[1:0] == 2'b11);
  assign have_instr = head_is32 ? (count_q >= 3'd2) : (count_q >= 3'd1);
  assign issue      = have_instr & ~flush_fetch_stage_i & ~stall_fetch_stage_i & ~ext_redirect;
  assign instr_word = head_is32 ? buf_q[31:0] : {16'h0000, buf_q[15:0]};
  assign pop        = issue ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;

`ifdef FETCH_STATIC_PREDICT_EN
  logic        is_jal, is_bwd_branch;
  logic [31:0] jal_imm, br_imm;

  assign is_jal        = (instr_word[6:0] == 7'b1101111);
  assign is_bwd_branch = (instr_word[6:0] == 7'b1100011) & instr_word[31];
  assign jal_imm       = {{12{instr_word[31]}}, instr_word[19:12], instr_word[20],
                          instr_word[30:21], 1'b0};
  assign br_imm        = {{20{instr_word[31]}}, instr_word[7], instr_word[30:25],
                          instr_word[11:8], 1'b0};
  assign pred_taken    = issue & head_is32 & (is_jal | is_bwd_branch);
  assign pred_target   = issue_pc_q + (is_jal ? jal_imm : br_imm);
`else
  assign pred_taken  = 1'b0;
  assign pred_target = issue_pc_q;
`endif

  // A predicted-taken branch redirects fetch like an external redirect.
  // pred_taken already implies that no external redirect is present.
  assign redirect        = ext_redirect | pred_taken;
  assign redirect_target = ext_redirect ? ext_target : pred_target;

  // Request only while at most 2 halfwords are buffered, so the reply always fits.
  assign imem.imem_req_o  = rst_i & (state_q == ST_REQ) & (count_q <= 3'd2);
  assign imem.imem_addr_o = fetch_addr_q;

  assign req_accept = imem.imem_req_o & imem.imem_ready_i;
  assign write_en   = (state_q == ST_WAIT) & imem.imem_valid_i & ~redirect;

  assign count_pop = count_q - {1'b0, pop};
  assign buf_pop   = buf_q >> {pop, 4'b0000};
  assign wr_data   = drop_low_q ? {48'h0, imem.imem_data_i[31:16]} : {32'h0, imem.imem_data_i};
  assign wr_cnt    = drop_low_q ? 3'd1 : 3'd2;

  // Next-state logic for the request FSM, parcel buffer and the two PCs.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_pop;
    count_d      = count_pop;
    fetch_addr_d = fetch_addr_q;
    drop_low_d   = drop_low_q;
    issue_pc_d   = issue_pc_q;

    unique case (state_q)
      ST_REQ:     if (req_accept) state_d = ST_WAIT;
      ST_WAIT:    if (imem.imem_valid_i) state_d = ST_REQ;
      ST_DISCARD: if (imem.imem_valid_i) state_d = ST_REQ;
      default:    state_d = ST_REQ;
    endcase

    if (issue) begin
      issue_pc_d = issue_pc_q + (head_is32 ? 32'd4 : 32'd2);
    end

    if (write_en) begin
      buf_d        = buf_pop | (wr_data << {count_pop, 4'b0000});
      count_d      = count_pop + wr_cnt;
      fetch_addr_d = fetch_addr_q + 32'd4;
      drop_low_d   = 1'b0;
    end

    if (redirect) begin
      buf_d        = 64'h0;
      count_d      = 3'd0;
      fetch_addr_d = {redirect_target[31:2], 2'b00};
      drop_low_d   = redirect_target[1];
      issue_pc_d   = {redirect_target[31:1], 1'b0};
      // A reply is still owed if a request is in flight or was accepted on this edge.
      // A reply arriving on this very edge is simply dropped.
      if ((state_q == ST_REQ && req_accept) ||
          (state_q != ST_REQ && !imem.imem_valid_i)) begin
        state_d = ST_DISCARD;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_REQ;
      buf_q        <= 64'h0;
      count_q      <= 3'd0;
      fetch_addr_q <= RESET_FETCH;
      drop_low_q   <= RESET_PC[1];
      issue_pc_q   <= RESET_ISSUE;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      drop_low_q   <= drop_low_d;
      issue_pc_q   <= issue_pc_d;
    end
  end

  // Decode-facing output registers. A flush or external redirect wins over a stall.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instruction_o     <= NOP_INSTR;
      program_counter_o <= 32'h0;
      branch_taken_o    <= 1'b0;
    end else if (flush_fetch_stage_i || ext_redirect) begin
      instruction_o  <= NOP_INSTR;
      branch_taken_o <= 1'b0;
    end else if (!stall_fetch_stage_i) begin
      if (have_instr) begin
        instruction_o     <= instr_word;
        program_counter_o <= issue_pc_q;
        branch_taken_o    <= pred_taken;
      end else begin
        instruction_o  <= NOP_INSTR;
        branch_taken_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed, table-driven bench for fetch_stage. Each row holds the inputs for one
// clock cycle. It also holds the expected request/address during that cycle and
// the expected decode outputs after the edge. A hand-written sequence covers
// reset asserted in the middle of a transaction.
// When built with FETCH_STATIC_PREDICT_EN, the expectations of the branch rows
// switch to the predicted behaviour.

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_STATIC_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        flush;
    logic        exc_en;
    logic [31:0] exc_pc;
    logic        br_en;
    logic [31:0] br_pc;
    logic        ready;
    logic        valid;
    logic [31:0] data;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_bt;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_fetch_stage_i = 1'b0;
  logic        flush_fetch_stage_i = 1'b0;
  logic        en_excep_program_counter_i = 1'b0;
  logic [31:0] excep_program_counter_i = 32'h0;
  logic        en_branch_redirect_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [31:0] instruction_o;
  logic [31:0] program_counter_o;
  logic        branch_taken_o;

  int checks = 0;
  int errors = 0;
  int row    = 0;
  vec_t tbl[$];

  fetch_stage_if imem_bus();

  fetch_stage dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .stall_fetch_stage_i        (stall_fetch_stage_i),
    .flush_fetch_stage_i        (flush_fetch_stage_i),
    .en_excep_program_counter_i (en_excep_program_counter_i),
    .excep_program_counter_i    (excep_program_counter_i),
    .en_branch_redirect_i       (en_branch_redirect_i),
    .branch_target_i            (branch_target_i),
    .imem                       (imem_bus),
    .instruction_o              (instruction_o),
    .program_counter_o          (program_counter_o),
    .branch_taken_o             (branch_taken_o)
  );

  always #5 clk_i = ~clk_i;

  // Safety net so that the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(input int st, input int fl, input int ex, input logic [31:0] ex_pc,
                              input int br, input logic [31:0] br_pc, input int rdy, input int vld,
                              input logic [31:0] dat, input int e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_instr, input logic [31:0] e_pc, input int e_bt);
    vec_t v;
    v.stall     = (st != 0);
    v.flush     = (fl != 0);
    v.exc_en    = (ex != 0);
    v.exc_pc    = ex_pc;
    v.br_en     = (br != 0);
    v.br_pc     = br_pc;
    v.ready     = (rdy != 0);
    v.valid     = (vld != 0);
    v.data      = dat;
    v.exp_req   = (e_req != 0);
    v.exp_addr  = e_addr;
    v.exp_instr = e_instr;
    v.exp_pc    = e_pc;
    v.exp_bt    = (e_bt != 0);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL row%0d %s: got %h expected %h", row, name, actual, expected);
    end
  endtask

  // Entered at a negedge; returns at the following negedge.
  task automatic applyStimulus(input vec_t v);
    stall_fetch_stage_i        = v.stall;
    flush_fetch_stage_i        = v.flush;
    en_excep_program_counter_i = v.exc_en;
    excep_program_counter_i    = v.exc_pc;
    en_branch_redirect_i       = v.br_en;
    branch_target_i            = v.br_pc;
    imem_bus.imem_ready_i      = v.ready;
    imem_bus.imem_valid_i      = v.valid;
    imem_bus.imem_data_i       = v.data;
    #1;
    checkOutput("imem_req", {31'h0, imem_bus.imem_req_o}, {31'h0, v.exp_req});
    checkOutput("imem_addr", imem_bus.imem_addr_o, v.exp_addr);
    @(posedge clk_i);
    #1;
    checkOutput("instruction", instruction_o, v.exp_instr);
    checkOutput("program_counter", program_counter_o, v.exp_pc);
    checkOutput("branch_taken", {31'h0, branch_taken_o}, {31'h0, v.exp_bt});
    @(negedge clk_i);
  endtask

  initial begin
    imem_bus.imem_ready_i = 1'b0;
    imem_bus.imem_valid_i = 1'b0;
    imem_bus.imem_data_i  = 32'h0;

    //    st fl ex ex_pc   br br_pc   rdy vld data           req addr      instr         pc       bt
    // Aligned 32-bit word with a 1-cycle memory
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h000, NOP,          32'h000, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'h0050_0093,  0,32'h000, NOP,          32'h000, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h004, 32'h00500093, 32'h000, 0));
    // RVC pair issues back-to-back
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h004, NOP,          32'h000, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'h4505_4501,  0,32'h004, NOP,          32'h000, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h008, 32'h00004501, 32'h004, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h008, 32'h00004505, 32'h006, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h008, NOP,          32'h006, 0));
    // 32-bit instruction straddling two words
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h008, NOP,          32'h006, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'h0093_4501,  0,32'h008, NOP,          32'h006, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h00C, 32'h00004501, 32'h008, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'h4505_0050,  0,32'h00C, NOP,          32'h008, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          0,32'h010, 32'h00500093, 32'h00A, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h010, 32'h00004505, 32'h00E, 0));
    // Branch redirect to 0x106 while waiting; pending response discarded
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h010, NOP,          32'h00E, 0));
    tbl.push_back(mk(0,0,0,32'h0,1,32'h106,0,0,32'h0,          0,32'h010, NOP,          32'h00E, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'hDEAD_BEEF,  0,32'h104, NOP,          32'h00E, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h104, NOP,          32'h00E, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'h4509_0093,  0,32'h104, NOP,          32'h00E, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h108, 32'h00004509, 32'h106, 0));
    // Stall with responses arriving, buffer fills, then flush during stall
    tbl.push_back(mk(1,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h108, 32'h00004509, 32'h106, 0));
    tbl.push_back(mk(1,0,0,32'h0,0,32'h0,  0,1,32'h4515_4511,  0,32'h108, 32'h00004509, 32'h106, 0));
    tbl.push_back(mk(1,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h10C, 32'h00004509, 32'h106, 0));
    tbl.push_back(mk(1,0,0,32'h0,0,32'h0,  0,1,32'h00A0_0513,  0,32'h10C, 32'h00004509, 32'h106, 0));
    tbl.push_back(mk(1,1,0,32'h0,0,32'h0,  1,0,32'h0,          0,32'h110, NOP,          32'h106, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          0,32'h110, 32'h00004511, 32'h108, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          0,32'h110, 32'h00004515, 32'h10A, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h110, 32'h00A00513, 32'h10C, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h110, NOP,          32'h10C, 0));
    // Exception beats branch redirect; request accepted on the same edge is discarded
    tbl.push_back(mk(0,0,1,32'h200,1,32'h300,1,0,32'h0,        1,32'h110, NOP,          32'h10C, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'h4501_4501,  0,32'h200, NOP,          32'h10C, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h200, NOP,          32'h10C, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'h4521_4519,  0,32'h200, NOP,          32'h10C, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h204, 32'h00004519, 32'h200, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h204, 32'h00004521, 32'h202, 0));
    // BEQ at 0x20 with offset -16
    tbl.push_back(mk(0,0,0,32'h0,1,32'h020,0,0,32'h0,          1,32'h204, NOP,          32'h202, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,32'h020, NOP,          32'h202, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'hFE00_08E3,  0,32'h020, NOP,          32'h202, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,32'h024, 32'hFE0008E3, 32'h020, PRED ? 1 : 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,PRED ? 32'h010 : 32'h024, NOP, 32'h020, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,1,32'h0000_0013,  0,PRED ? 32'h010 : 32'h024, NOP, 32'h020, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  0,0,32'h0,          1,PRED ? 32'h014 : 32'h028,
                     32'h00000013, PRED ? 32'h010 : 32'h024, 0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,  1,0,32'h0,          1,PRED ? 32'h014 : 32'h028,
                     NOP, PRED ? 32'h010 : 32'h024, 0));

    // Reset state while reset is held
    repeat (2) @(negedge clk_i);
    row = -1;
    checkOutput("reset imem_req", {31'h0, imem_bus.imem_req_o}, 32'h0);
    checkOutput("reset imem_addr", imem_bus.imem_addr_o, 32'h0);
    checkOutput("reset instruction", instruction_o, NOP);
    checkOutput("reset program_counter", program_counter_o, 32'h0);
    checkOutput("reset branch_taken", {31'h0, branch_taken_o}, 32'h0);
    rst_i = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      row = i;
      applyStimulus(tbl[i]);
    end

    // Reset asserted while a request is in flight; the late response must be ignored
    imem_bus.imem_ready_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    row = 100;
    checkOutput("midreset imem_req", {31'h0, imem_bus.imem_req_o}, 32'h0);
    checkOutput("midreset imem_addr", imem_bus.imem_addr_o, 32'h0);
    checkOutput("midreset instruction", instruction_o, NOP);
    checkOutput("midreset program_counter", program_counter_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    row = 101;
    applyStimulus(mk(0,0,0,32'h0,0,32'h0, 0,1,32'h4501_4501, 1,32'h000, NOP, 32'h000, 0));
    row = 102;
    applyStimulus(mk(0,0,0,32'h0,0,32'h0, 0,0,32'h0,         1,32'h000, NOP, 32'h000, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
